// File: rtl/nibble_serial_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple adder, reused once per nibble step by the serial adder.
module nibble_adder
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout = carry[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per clock, LSB nibble first.
// Optional signed-overflow output is enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid never depends combinationally on ready.

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  int unsigned         base;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;

  always_comb begin
    base = 32'(cnt) * NIBBLE_W;
  end

  nibble_adder u_nibble_adder (
    .a    (op_a[base +: NIBBLE_W]),
    .b    (op_b[base +: NIBBLE_W]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          out_sum[base +: NIBBLE_W] <= nib_sum;
          carry <= nib_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // Top-nibble carry leaves through out_cout only; it is not recirculated.
            out_cout  <= nib_cout;
            out_valid <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            out_ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                         (nib_sum[NIBBLE_W-1] != op_a[WIDTH-1]);
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic        out_ovf;
`endif

  int total = 0;
  int bad   = 0;
  int lat;
  logic [15:0] held_sum;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands at negedge, let them be accepted, then scramble the inputs.
  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    chk({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_cin = ~cin;
    chk({tag, "_busy_add"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_add"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_result(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, "_sum"}, 32'(out_sum), 32'(es));
    chk({tag, "_cout"}, 32'(out_cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x on ovf expectation for %s", tag);
`endif
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic ec, input logic eo);
    out_ready = 1'b1;
    send(tag, a, b, cin);
    wait_valid(tag);
    check_result(tag, es, ec, eo);
    @(posedge clk); #1;
    chk({tag, "_valid_one_cycle"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_sum", 32'(out_sum), 32'h0000);
    chk("rst_out_cout", 32'(out_cout), 32'd0);

    do_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("mixed", 16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: consumer stalls while a new operand set waits at the input.
    out_ready = 1'b0;
    send("bp", 16'h0F0F, 16'h00F1, 1'b0);
    wait_valid("bp");
    check_result("bp", 16'h1000, 1'b0, 1'b0);
    held_sum = out_sum;
    @(negedge clk);
    in_a = 16'hABCD; in_b = 16'h1234; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(out_sum), 32'(held_sum));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_next_accept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; in_cin = 1'b0;
    wait_valid("bp_next");
    check_result("bp_next", 16'hBE02, 1'b0, 1'b0);
    @(posedge clk); #1;

    // Reset two cycles into ADD must abort at once.
    send("abort", 16'h1234, 16'h1111, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_sum", 32'(out_sum), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_abort", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("ovf_none", 16'h0003, 16'hFFFE, 1'b0, 16'h0001, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
